// File: rtl/safety_check_multi_if.sv
// Sample/fault bundle between the ADC/DAC register paths and the multi-channel
// amplifier safety check.
interface safety_check_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int IDX_W  = 2
);
  logic [NUM_CH*WIDTH-1:0] cur;
  logic [NUM_CH*WIDTH-1:0] dac;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       fault_clr;
  logic [NUM_CH-1:0]       amp_disable;
  logic                    fault_any;
  logic [IDX_W-1:0]        first_fault;
  logic                    first_valid;

  modport master (
    output cur, dac, ch_enable, fault_clr,
    input  amp_disable, fault_any, first_fault, first_valid
  );

  modport slave (
    input  cur, dac, ch_enable, fault_clr,
    output amp_disable, fault_any, first_fault, first_valid
  );
endinterface

// File: rtl/safety_check_multi.sv
// Multi-channel amplifier over-current check: per-channel consecutive-error
// counters latching an amplifier-disable fault, with first-fault capture.
module safety_check_ch #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] MID        = 16'h7FFF,
  parameter logic [WIDTH-1:0] DEADBAND   = 16'h0300,
  parameter int               GAIN_SHIFT = 1,
  parameter int               CNT_WIDTH  = 24,
  parameter int               LIMIT      = 2457600
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] dac,
  input  logic             enable,
  input  logic             clr,
  output logic             fault,
  output logic             fault_nxt
);
  localparam int SW = WIDTH + GAIN_SHIFT;
  localparam logic [CNT_WIDTH-1:0] LIM = CNT_WIDTH'(LIMIT);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {ST_OK, ST_COUNT, ST_FAULT} state_t;

  state_t               state_q, state_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n, cnt_inc;
  logic [WIDTH-1:0]     abs_cur, abs_dac;
  logic [SW-1:0]        dac_sc;
  logic                 err;

  // Stage 1: magnitude about the offset-binary midpoint
  always_ff @(posedge clk) begin
    if (reset) begin
      abs_cur <= '0;
      abs_dac <= '0;
    end else begin
      abs_cur <= (cur > MID) ? cur - MID : MID - cur;
      abs_dac <= (dac > MID) ? dac - MID : MID - dac;
    end
  end

  // Scaled command kept at full width so large commands never alias small
  assign dac_sc  = SW'(abs_dac) << GAIN_SHIFT;
  assign err     = enable && (abs_cur >= DEADBAND) && (SW'(abs_cur) > dac_sc);
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      ST_OK: begin
        if (err) begin
          cnt_n   = ONE;
          state_n = (ONE == LIM) ? ST_FAULT : ST_COUNT;
        end else begin
          cnt_n = '0;
        end
      end
      ST_COUNT: begin
        if (err) begin
          cnt_n = cnt_inc;
          if (cnt_inc == LIM) state_n = ST_FAULT;
        end else begin
          cnt_n   = '0;
          state_n = ST_OK;
        end
      end
      ST_FAULT: begin
        // Only an explicit clear releases the latch; enable and err are ignored
        if (clr) begin
          cnt_n   = '0;
          state_n = ST_OK;
        end else begin
          cnt_n = LIM;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_OK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  assign fault     = (state_q == ST_FAULT);
  assign fault_nxt = (state_n == ST_FAULT);
endmodule

module safety_check_multi #(
  parameter int               NUM_CH     = 4,
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] MID        = 16'h7FFF,
  parameter logic [WIDTH-1:0] DEADBAND   = 16'h0300,
  parameter int               GAIN_SHIFT = 1,
  parameter int               CNT_WIDTH  = 24,
  parameter int               LIMIT      = 2457600,
  parameter int               IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic                 clk,
  input logic                 reset,
  safety_check_multi_if.slave bus
);
  logic [NUM_CH-1:0] fault_q, fault_n, enter;
  logic [IDX_W-1:0]  first_idx, first_fault_q;
  logic              fault_any_q, first_valid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    safety_check_ch #(
      .WIDTH(WIDTH), .MID(MID), .DEADBAND(DEADBAND), .GAIN_SHIFT(GAIN_SHIFT),
      .CNT_WIDTH(CNT_WIDTH), .LIMIT(LIMIT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cur       (bus.cur[i*WIDTH +: WIDTH]),
      .dac       (bus.dac[i*WIDTH +: WIDTH]),
      .enable    (bus.ch_enable[i]),
      .clr       (bus.fault_clr[i]),
      .fault     (fault_q[i]),
      .fault_nxt (fault_n[i])
    );
  end

  assign enter = fault_n & ~fault_q;

  // Lowest-index channel entering fault this edge
  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (enter[i]) first_idx = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_any_q   <= 1'b0;
      first_fault_q <= '0;
      first_valid_q <= 1'b0;
    end else begin
      fault_any_q <= |fault_n;
      if (fault_n == '0) begin
        first_fault_q <= '0;
        first_valid_q <= 1'b0;
      end else if (!first_valid_q && (enter != '0)) begin
        first_fault_q <= first_idx;
        first_valid_q <= 1'b1;
      end
    end
  end

  assign bus.amp_disable = fault_q;
  assign bus.fault_any   = fault_any_q;
  assign bus.first_fault = first_fault_q;
  assign bus.first_valid = first_valid_q;
endmodule

// File: doc/safety_check_multi.md
Name: safety_check_multi

Overview:
Parametrised multi-channel successor to the single-channel amplifier safety check. For each motor channel it compares the measured current magnitude (ADC feedback) against the commanded magnitude (DAC), and counts consecutive over-current samples. It latches a per-channel amplifier-disable fault when the count reaches a programmable limit. It sits between the ADC/DAC register paths and the amplifier-enable logic, and adds per-channel enable, explicit fault clear, and first-fault capture.

Parameters:
NUM_CH, 4, number of motor channels
WIDTH, 16, bit width of cur_in/dac_in samples per channel
MID, 16'h7FFF, zero-current code (offset-binary midpoint)
DEADBAND, 16'h0300, magnitudes strictly below this never count as errors
GAIN_SHIFT, 1, commanded magnitude is scaled by 2^GAIN_SHIFT before comparison
CNT_WIDTH, 24, error counter width
LIMIT, 2457600, consecutive error samples required to trip (1 <= LIMIT < 2^CNT_WIDTH)
IDX_W, 2, width of first_fault (derived as clog2(NUM_CH), minimum 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cur_in  input  NUM_CH*WIDTH  feedback currents; channel i at [i*WIDTH +: WIDTH]
dac_in  input  NUM_CH*WIDTH  commanded currents; same packing
ch_enable  input  NUM_CH  per-channel monitoring enable
fault_clr  input  NUM_CH  per-channel fault-clear request (level sampled each clk)
amp_disable  output  NUM_CH  per-channel latched fault / amplifier disable
fault_any  output  1  OR of amp_disable, registered
first_fault  output  IDX_W  index of the channel that caused the first fault
first_valid  output  1  first_fault holds a captured index

Behaviour:
- Reset: the only reset is reset=1 sampled at a clk edge. It zeroes all stage-1 registers and counters, puts every channel in OK, and sets amp_disable=0, fault_any=0, first_fault=0, first_valid=0. Reset overrides all other inputs, including a reset asserted mid-count or mid-fault.
- Stage 1 (1 clk): abs_cur = (cur>MID) ? cur-MID : MID-cur, WIDTH bits. abs_dac is computed the same way from dac_in.
- Stage 2 error term: err_i = ch_enable_i && (abs_cur_i >= DEADBAND) && (abs_cur_i > (abs_dac_i << GAIN_SHIFT)).
  - The shifted term is WIDTH+GAIN_SHIFT bits wide with no truncation.
  - Comparisons are unsigned.
  - Only registered stage-1 values are used; there is no raw-input path.
- Per-channel state machine: OK, COUNT, FAULT.
  - OK: if err, counter=1 and go to COUNT (or straight to FAULT if LIMIT==1). Otherwise counter=0.
  - COUNT: if err, counter+1. When the incremented value equals LIMIT, go to FAULT. If !err, counter=0 and go to OK (the count is of consecutive samples only).
  - FAULT: counter held at LIMIT. Leave only when fault_clr_i=1, which sets counter=0 and returns to OK that edge. err is ignored while in FAULT.
  - ch_enable_i=0 in OK/COUNT: counter=0, state OK. ch_enable_i=0 in FAULT: the fault stays latched; disabling never clears a fault.
  - fault_clr_i in OK/COUNT: no effect (err continues to count).
  - fault_clr_i and err on the same edge in FAULT: clear wins. The next err sample starts a new count from 1.
- amp_disable_i is registered and equals (state==FAULT). It rises on the same edge the state enters FAULT.
- Latency: with the error condition present on the inputs before edge 0, amp_disable rises at edge LIMIT (LIMIT+1 edges after the inputs are applied).
- fault_any is registered from the next-state amp_disable vector, so it rises on the same edge as amp_disable.
- first_fault and first_valid:
  - When first_valid=0 and one or more channels enter FAULT on an edge, first_fault is set to the lowest such index and first_valid=1.
  - Later faults do not overwrite it.
  - first_valid returns to 0, and first_fault to 0, on the edge where no channel remains in FAULT.
- Counter never wraps: it saturates at LIMIT via the FAULT state.

Test Plan:
- Reset mid-count: LIMIT=8, channel 0 counting at 5, assert reset 1 clk -> all counters 0, amp_disable=0, first_valid=0 the next cycle; reset dominates even with err held.
- Trip latency: LIMIT=8, ch0 cur=0x9000 (abs 0x1001), dac=0x8100 (abs 0x0101, scaled 0x0202), enable=1 -> amp_disable[0]=1 exactly at edge 8 after the inputs are applied; fault_any=1 the same edge; first_fault=0, first_valid=1.
- Consecutive requirement and deadband: errors for 7 samples, then cur=0x8200 (abs 0x0201 < DEADBAND) for 1 sample, then errors again -> no trip until 8 further consecutive samples; cur=0x7D00..0x82FE never counts regardless of dac.
- Command tracking: cur=0x9000, dac=0x8900 (abs 0x0901, scaled 0x1202 > 0x1001) held for 100 samples -> no count, amp_disable stays 0; cur=0x6000 (abs 0x1FFF), dac=0x7FFF (abs 0) -> trips at edge 8.
- Clear and enable: ch1 faulted, drop ch_enable[1] -> stays faulted; pulse fault_clr[1] while err still present -> amp_disable[1]=0 next edge, re-trips 8 edges later; fault_clr on a non-faulted channel -> no effect.
- Simultaneous and ordered faults: ch3 and ch1 trip on the same edge -> first_fault=1; ch2 trips later -> first_fault stays 1; clear ch1 and ch3 but not ch2 -> first_valid stays 1; clear ch2 -> first_valid=0, first_fault=0.
